// File: rtl/elevator.sv
// Single-car LOOK-policy elevator controller for a five-floor building.
// Latches floor requests, steps the car one floor per MOVE_CYCLES, and
// holds the door open for DOOR_CYCLES after the last door activity.
module elevator #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] buttons,
  input  logic       come_in,
  input  logic       go_out,
  output logic [2:0] current_floor,
  output logic       going_up,
  output logic       going_down
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES);
  localparam logic [TW-1:0] ONE       = TW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t        state, state_n;
  dir_t          dir, dir_n;
  logic [2:0]    floor, floor_n;
  logic [4:0]    pending, pending_n;
  logic [TW-1:0] timer, timer_n;

  // One-hot mask for a floor number 1..5.
  function automatic logic [4:0] floor_bit(input logic [2:0] f);
    floor_bit = 5'b00001 << (f - 3'd1);
  endfunction

  // LOOK direction choice: keep sweeping while work lies ahead, otherwise
  // reverse; from rest head for the nearest request, preferring up on a tie.
  function automatic dir_t decide(input dir_t d, input logic [4:0] r, input logic [2:0] f);
    logic any_up, any_dn;
    int   up_dist, dn_dist, idx;
    idx     = int'(f) - 1;
    any_up  = 1'b0;
    any_dn  = 1'b0;
    up_dist = 0;
    dn_dist = 0;
    for (int i = 0; i < 5; i++) begin
      if (r[i] && i > idx && !any_up) begin
        any_up  = 1'b1;
        up_dist = i - idx;
      end
    end
    for (int i = 4; i >= 0; i--) begin
      if (r[i] && i < idx && !any_dn) begin
        any_dn  = 1'b1;
        dn_dist = idx - i;
      end
    end
    decide = DIR_NONE;
    case (d)
      DIR_UP: begin
        if (any_up)      decide = DIR_UP;
        else if (any_dn) decide = DIR_DOWN;
      end
      DIR_DOWN: begin
        if (any_dn)      decide = DIR_DOWN;
        else if (any_up) decide = DIR_UP;
      end
      default: begin
        if (any_up && (!any_dn || up_dist <= dn_dist)) decide = DIR_UP;
        else if (any_dn)                              decide = DIR_DOWN;
      end
    endcase
  endfunction

  // Register the controller state; reset drops all requests and parks the car at floor 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      dir     <= DIR_NONE;
      floor   <= 3'd1;
      pending <= '0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      floor   <= floor_n;
      pending <= pending_n;
      timer   <= timer_n;
    end
  end

  // Next-state logic: request latching, floor stepping, door dwell and sweep decisions.
  always_comb begin
    logic [4:0] all_req, cur, req, clear;
    logic [2:0] step;
    dir_t       d;
    state_n = state;
    dir_n   = dir;
    floor_n = floor;
    timer_n = timer;
    clear   = '0;
    step    = floor;
    d       = DIR_NONE;
    all_req = pending | buttons;
    cur     = floor_bit(floor);
    req     = all_req & ~cur;
    case (state)
      S_IDLE: begin
        if (|(all_req & cur)) begin
          state_n = S_DOOR;
          clear   = cur;
          timer_n = DOOR_LOAD;
        end else if (|req) begin
          state_n = S_MOVE;
          dir_n   = decide(dir, req, floor);
          timer_n = MOVE_LOAD;
        end
      end
      S_MOVE: begin
        if (timer > ONE) begin
          timer_n = timer - ONE;
        end else begin
          if (dir == DIR_UP && floor < 3'd5)        step = floor + 3'd1;
          else if (dir == DIR_DOWN && floor > 3'd1) step = floor - 3'd1;
          floor_n = step;
          if (|(all_req & floor_bit(step))) begin
            state_n = S_DOOR;
            clear   = floor_bit(step);
            timer_n = DOOR_LOAD;
          end else begin
            timer_n = MOVE_LOAD;
          end
        end
      end
      S_DOOR: begin
        clear = cur;
        if (come_in || go_out || (|(buttons & cur))) begin
          timer_n = DOOR_LOAD;
        end else if (timer > ONE) begin
          timer_n = timer - ONE;
        end else begin
          d = decide(dir, req, floor);
          if (d == DIR_NONE) begin
            state_n = S_IDLE;
            dir_n   = DIR_NONE;
          end else begin
            state_n = S_MOVE;
            dir_n   = d;
            timer_n = MOVE_LOAD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    pending_n = all_req & ~clear;
  end

  assign current_floor = floor;
  assign going_up      = (dir == DIR_UP);
  assign going_down    = (dir == DIR_DOWN);

endmodule

// File: tb/tb_elevator.sv
// Self-checking bench for elevator: directed scenarios plus a randomized
// phase, all compared against a floor-level behavioural model.
module tb_elevator;

  localparam int MOVE = 4;
  localparam int DOOR = 3;

  logic       clk;
  logic       reset;
  logic [4:0] buttons;
  logic       come_in;
  logic       go_out;
  logic [2:0] current_floor;
  logic       going_up;
  logic       going_down;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 travelling, 2 door open; dir is +1/-1/0.
  int         m_mode;
  int         m_dir;
  int         m_floor;
  int         m_timer;
  logic [5:1] m_pend;

  elevator #(.MOVE_CYCLES(MOVE), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk),
    .reset(reset),
    .buttons(buttons),
    .come_in(come_in),
    .go_out(go_out),
    .current_floor(current_floor),
    .going_up(going_up),
    .going_down(going_down)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modelDecide(input int d, input int f, input logic [5:1] r);
    int nearUp, nearDn;
    nearUp = 99;
    nearDn = 99;
    for (int g = 1; g <= 5; g++) begin
      if (r[g] && g > f && g - f < nearUp) nearUp = g - f;
      if (r[g] && g < f && f - g < nearDn) nearDn = f - g;
    end
    if (d == 1)  return (nearUp < 99) ? 1 : ((nearDn < 99) ? -1 : 0);
    if (d == -1) return (nearDn < 99) ? -1 : ((nearUp < 99) ? 1 : 0);
    if (nearUp == 99 && nearDn == 99) return 0;
    return (nearUp <= nearDn) ? 1 : -1;
  endfunction

  task automatic modelReset();
    m_mode  = 0;
    m_dir   = 0;
    m_floor = 1;
    m_timer = 0;
    m_pend  = '0;
  endtask

  task automatic modelStep(input logic [4:0] b, input logic ci, input logic go);
    logic [5:1] all;
    all = m_pend | b;
    case (m_mode)
      0: begin
        if (all[m_floor]) begin
          all[m_floor] = 1'b0;
          m_mode  = 2;
          m_timer = DOOR;
        end else if (all != 0) begin
          m_dir   = modelDecide(m_dir, m_floor, all);
          m_mode  = 1;
          m_timer = MOVE;
        end
      end
      1: begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin
          m_floor = m_floor + m_dir;
          if (all[m_floor]) begin
            all[m_floor] = 1'b0;
            m_mode  = 2;
            m_timer = DOOR;
          end else begin
            m_timer = MOVE;
          end
        end
      end
      default: begin
        all[m_floor] = 1'b0;
        if (ci || go || b[m_floor-1]) begin
          m_timer = DOOR;
        end else begin
          m_timer = m_timer - 1;
          if (m_timer == 0) begin
            m_dir = modelDecide(m_dir, m_floor, all);
            if (m_dir == 0) begin
              m_mode = 0;
            end else begin
              m_mode  = 1;
              m_timer = MOVE;
            end
          end
        end
      end
    endcase
    m_pend = all;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (current_floor === 3'(m_floor)) else begin
      errors++;
      $error("[TB] FAIL %s floor: observed %0d expected %0d", tag, current_floor, m_floor);
    end
    checks++;
    assert (going_up === (m_dir == 1)) else begin
      errors++;
      $error("[TB] FAIL %s going_up: observed %b expected %b", tag, going_up, (m_dir == 1));
    end
    checks++;
    assert (going_down === (m_dir == -1)) else begin
      errors++;
      $error("[TB] FAIL %s going_down: observed %b expected %b", tag, going_down, (m_dir == -1));
    end
  endtask

  task automatic expectState(input string tag, input int f, input logic up, input logic dn);
    checks++;
    assert (current_floor === 3'(f) && going_up === up && going_down === dn) else begin
      errors++;
      $error("[TB] FAIL %s: observed floor %0d up %b down %b expected floor %0d up %b down %b",
             tag, current_floor, going_up, going_down, f, up, dn);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic ci, input logic go, input string tag);
    @(negedge clk);
    buttons = b;
    come_in = ci;
    go_out  = go;
    @(posedge clk);
    modelStep(b, ci, go);
    #1;
    checkOutput(tag);
  endtask

  task automatic runIdle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(5'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [4:0] rb;
    logic       rci, rgo;
    reset   = 1'b1;
    buttons = '0;
    come_in = 1'b0;
    go_out  = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    expectState("reset_values", 1, 1'b0, 1'b0);
    reset = 1'b0;

    $display("[TB] reset and quiet idle");
    runIdle(5, "quiet");
    expectState("quiet_stable", 1, 1'b0, 1'b0);

    $display("[TB] single request to floor 4");
    applyStimulus(5'b01000, 1'b0, 1'b0, "to4_start");
    expectState("to4_dir_up", 1, 1'b1, 1'b0);
    runIdle(4, "to4");
    expectState("to4_floor2", 2, 1'b1, 1'b0);
    runIdle(4, "to4");
    expectState("to4_floor3", 3, 1'b1, 1'b0);
    runIdle(4, "to4");
    expectState("to4_floor4", 4, 1'b1, 1'b0);
    runIdle(2, "to4_door");
    expectState("to4_door_open", 4, 1'b1, 1'b0);
    runIdle(1, "to4_door");
    expectState("to4_idle", 4, 1'b0, 1'b0);

    $display("[TB] request at current floor");
    applyStimulus(5'b00100, 1'b0, 1'b0, "to3_start");
    expectState("to3_dir_down", 4, 1'b0, 1'b1);
    runIdle(4, "to3");
    expectState("to3_arrive", 3, 1'b0, 1'b1);
    runIdle(3, "to3_door");
    expectState("to3_idle", 3, 1'b0, 1'b0);
    applyStimulus(5'b00100, 1'b0, 1'b0, "here_door");
    expectState("here_door", 3, 1'b0, 1'b0);
    runIdle(3, "here_door");
    expectState("here_idle", 3, 1'b0, 1'b0);

    $display("[TB] sweep up then down");
    applyStimulus(5'b00001, 1'b0, 1'b0, "to1");
    runIdle(11, "to1");
    expectState("at_floor1", 1, 1'b0, 1'b0);
    applyStimulus(5'b00100, 1'b0, 1'b0, "sweep");
    applyStimulus(5'b10000, 1'b0, 1'b0, "sweep");
    runIdle(3, "sweep");
    expectState("sweep_floor2", 2, 1'b1, 1'b0);
    applyStimulus(5'b00010, 1'b0, 1'b0, "sweep_req2");
    runIdle(3, "sweep");
    expectState("sweep_stop3", 3, 1'b1, 1'b0);
    runIdle(11, "sweep");
    expectState("sweep_stop5", 5, 1'b1, 1'b0);
    runIdle(3, "sweep");
    expectState("sweep_reverse", 5, 1'b0, 1'b1);
    runIdle(12, "sweep");
    expectState("sweep_stop2", 2, 1'b0, 1'b1);
    runIdle(3, "sweep");
    expectState("sweep_idle", 2, 1'b0, 1'b0);

    $display("[TB] door held by come_in");
    applyStimulus(5'b00010, 1'b0, 1'b0, "hold_open");
    for (int k = 1; k <= 6; k++) applyStimulus(5'b0, (k % 2 == 0), 1'b0, "hold");
    applyStimulus(5'b00001, 1'b0, 1'b0, "hold_req1");
    runIdle(1, "hold");
    expectState("hold_still_open", 2, 1'b0, 1'b0);
    runIdle(1, "hold");
    expectState("hold_closed_move", 2, 1'b0, 1'b1);
    runIdle(7, "hold");
    expectState("hold_at1", 1, 1'b0, 1'b0);

    $display("[TB] async reset mid-move");
    applyStimulus(5'b10000, 1'b0, 1'b0, "rst_move");
    runIdle(9, "rst_move");
    expectState("rst_floor3", 3, 1'b1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    expectState("rst_async", 1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    runIdle(20, "rst_after");
    expectState("rst_request_lost", 1, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      rb  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
      rci = ($urandom_range(0, 9) == 0);
      rgo = ($urandom_range(0, 11) == 0);
      applyStimulus(rb, rci, rgo, "random");
    end
    runIdle(60, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
